hist_acq_ctrl: RTL

//  Acquisition/readout sequencer in front of the histogramming core.

---
 rtl/hist_ctrl_pkg.sv | 19 +
 rtl/hist_acq_ctrl_rr_arb2.sv | 34 +++
 rtl/hist_acq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hist_ctrl_pkg.sv
// hist_ctrl_pkg
//   Shared types and default widths for the histogram acquisition controller.
//   state_t   : sequencer states {IDLE, ACQ, DRAIN, REQ, READ}
//   DEF_DW    : default sample width
//   DEF_CNT_W : default sample/bin counter width
package hist_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACQ   = 3'd1,
    DRAIN = 3'd2,
    REQ   = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam int DEF_DW    = 16;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/hist_acq_ctrl_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. With one requester it grants that one; with
//   both it grants the source that was not served last. The last-served
//   pointer only moves on a completed transfer.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request (valid) per source
//   xfer       : a transfer to the granted source completed this cycle
//   grant      : 0 = source 0, 1 = source 1
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic       grant
);

  // Reset value 1 makes source 0 the preferred winner of the first tie.
  logic last;

  always_comb begin
    grant = ~last;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last <= 1'b1;
    else if (xfer) last <= grant;
  end

endmodule

// File: rtl/hist_acq_ctrl.sv
// hist_acq_ctrl
//   Acquisition/readout sequencer in front of the histogramming core.
//   Arbitrates two sample sources onto the core write port, counts FRAME_LEN
//   samples, requests the bin readout and counts readout beats to the last bin.
//   Optional readout timeout: define HIST_ACQ_CTRL_TIMEOUT_EN (adds TIMEOUT).
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   start, cont          : frame start pulse, continuous re-arm level
//   s0_*/s1_*            : source data/valid in, ready out (combinational)
//   hist_data, hist_we   : registered write to core
//   hist_ready           : core can accept a write
//   hist_rd_req          : one-cycle readout request
//   hist_valid/last      : readout beat and final-bin flag from core
//   busy, frame_done     : not idle, clean-readout pulse
//   bin_cnt, err         : readout beat count, sticky timeout flag
//
//   state | meaning
//   IDLE  | waiting for start
//   ACQ   | accepting samples from the arbitrated sources
//   DRAIN | last sample write is on its way to the core
//   REQ   | hist_rd_req asserted
//   READ  | counting readout beats until hist_last
module hist_acq_ctrl
  import hist_ctrl_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = DEF_CNT_W
`ifdef HIST_ACQ_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [DW-1:0]    s0_data,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [DW-1:0]    s1_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [DW-1:0]    hist_data,
  output logic             hist_we,
  input  logic             hist_ready,
  output logic             hist_rd_req,
  input  logic             hist_valid,
  input  logic             hist_last,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] bin_cnt,
  output logic             err
);

  state_t           state, state_nxt;
  logic             grant, xfer, acq_ok, cnt_tc, last_beat, timeout;
  logic [CNT_W-1:0] smp_cnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({s1_valid, s0_valid}),
    .xfer  (xfer),
    .grant (grant)
  );

  assign acq_ok    = (state == ACQ) && hist_ready && (smp_cnt < CNT_W'(FRAME_LEN));
  assign s0_ready  = acq_ok && !grant;
  assign s1_ready  = acq_ok && grant;
  assign xfer      = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign cnt_tc    = (smp_cnt == CNT_W'(FRAME_LEN - 1));
  assign last_beat = (state == READ) && hist_valid && hist_last;

`ifdef HIST_ACQ_CTRL_TIMEOUT_EN
  // Idle-cycle timer: reloaded outside READ and on every beat, expires on
  // the TIMEOUT-th consecutive beat-less READ cycle.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            tmr <= '0;
    else if (state != READ || hist_valid) tmr <= TMR_W'(TIMEOUT - 1);
    else if (tmr != '0)                   tmr <= tmr - 1'b1;
  end

  assign timeout = (state == READ) && !hist_valid && (tmr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    hist_rd_req = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = ACQ;
      ACQ:   if (xfer && cnt_tc) state_nxt = DRAIN;
      DRAIN: state_nxt = REQ;
      REQ: begin
        hist_rd_req = 1'b1;
        state_nxt   = READ;
      end
      READ: begin
        if (last_beat)    state_nxt = cont ? ACQ : IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter only matters in ACQ, so holding it at zero elsewhere gives
  // every frame a fresh count. bin_cnt keeps the last frame's total until the
  // next ACQ cycle clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_we    <= 1'b0;
      hist_data  <= '0;
      frame_done <= 1'b0;
      smp_cnt    <= '0;
      bin_cnt    <= '0;
    end else begin
      hist_we    <= xfer;
      frame_done <= last_beat;
      if (xfer) hist_data <= grant ? s1_data : s0_data;

      if (state != ACQ) smp_cnt <= '0;
      else if (xfer)    smp_cnt <= smp_cnt + 1'b1;

      if (state == ACQ)
        bin_cnt <= '0;
      else if (state == READ && hist_valid && bin_cnt != '1)
        bin_cnt <= bin_cnt + 1'b1;
    end
  end

endmodule
